// File: rtl/vote_pkg.sv
// vote_pkg: shared FSM state type, default session parameters, count-width helper
package vote_pkg;
  typedef enum logic [1:0] {IDLE, OPEN, TALLY, RESULT} state_e;
  localparam int N_VOTERS_DEF = 4;
  localparam int TIMEOUT_CYCLES_DEF = 16;
  localparam int PASS_THRESHOLD_DEF = 3;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/vote_tally.sv
// vote_tally: combinational popcount; in bits[N-1:0], out count[$clog2(N+1)-1:0]
module vote_tally import vote_pkg::*; #(
  parameter int N = N_VOTERS_DEF
) (
  input  logic [N-1:0]          bits,
  output logic [cnt_w(N)-1:0]   count
);
  localparam int CW = cnt_w(N);
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: voting session FSM; in clk rst_n start abort vote_valid vote_yes, out busy voted_mask done yes_count pass timed_out dup_err
module vote_session_ctrl import vote_pkg::*; #(
  parameter int N_VOTERS       = N_VOTERS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int PASS_THRESHOLD = PASS_THRESHOLD_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [N_VOTERS-1:0]           vote_valid,
  input  logic [N_VOTERS-1:0]           vote_yes,
  output logic                          busy,
  output logic [N_VOTERS-1:0]           voted_mask,
  output logic                          done,
  output logic [cnt_w(N_VOTERS)-1:0]    yes_count,
  output logic                          pass,
  output logic                          timed_out,
  output logic                          dup_err
);
  localparam int CW = cnt_w(N_VOTERS);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_e state_q, state_d;
  logic [N_VOTERS-1:0] mask_q, mask_d, ballot_q, ballot_d, acc;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] yes_q, yes_d, cnt;
  logic pass_q, pass_d, to_q, to_d, dup_q, dup_d, all_voted, last;
  vote_tally #(.N(N_VOTERS)) u_tally (.bits(ballot_q & mask_q), .count(cnt));
  assign acc = vote_valid & ~mask_q;
  assign all_voted = &(mask_q | acc);
  assign last = timer_q == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    ballot_d = ballot_q;
    timer_d = timer_q;
    yes_d = yes_q;
    pass_d = pass_q;
    to_d = to_q;
    dup_d = dup_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = OPEN;
        mask_d = '0;
        ballot_d = '0;
        timer_d = '0;
        to_d = 1'b0;
        dup_d = 1'b0;
      end
      OPEN: if (abort) begin
        state_d = IDLE;
        mask_d = '0;
      end else begin
        mask_d = mask_q | acc;
        ballot_d = (ballot_q & ~acc) | (vote_yes & acc);
        dup_d = dup_q | (|(vote_valid & mask_q));
        state_d = (all_voted || last) ? TALLY : OPEN;
        to_d = !all_voted && last;
        timer_d = (all_voted || last) ? timer_q : timer_q + 1'b1;
      end
      TALLY: if (abort) begin
        state_d = IDLE;
        mask_d = '0;
      end else begin
        state_d = RESULT;
        yes_d = cnt;
        pass_d = cnt >= CW'(PASS_THRESHOLD);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q <= '0;
      ballot_q <= '0;
      timer_q <= '0;
      yes_q <= '0;
      pass_q <= 1'b0;
      to_q <= 1'b0;
      dup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      ballot_q <= ballot_d;
      timer_q <= timer_d;
      yes_q <= yes_d;
      pass_q <= pass_d;
      to_q <= to_d;
      dup_q <= dup_d;
    end
  assign busy = state_q == OPEN || state_q == TALLY;
  assign done = state_q == RESULT;
  assign voted_mask = mask_q;
  assign yes_count = yes_q;
  assign pass = pass_q;
  assign timed_out = to_q;
  assign dup_err = dup_q;
endmodule
